// File: rtl/alu_seq.sv
// Multi-cycle execute stage: ADD/SUB/logic in one cycle, shifts one bit per cycle, MUL as 32-step shift-add.
// Latency: done 1 cycle after accept (single-cycle ops / zero shift), 1+n for shifts, 33 for MUL.
// No backpressure: start is taken only while busy=0; requests arriving while busy are dropped.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int SHW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              zero,
  output logic              carry,
  output logic              sign,
  output logic              illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLA = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;    // latched multiplicand
  logic [WIDTH-1:0] acc;    // shift operand, or product high half during MUL
  logic [WIDTH-1:0] mq;     // multiplier, becomes product low half
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;

  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   dif_ab;
  logic [WIDTH-1:0] c_res;
  logic             c_cry;
  logic             c_ill;
  logic             is_shift;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic             last;

  assign n        = b[SHW-1:0];
  assign sum_ab   = {1'b0, a} + {1'b0, b};
  assign dif_ab   = {1'b0, a} - {1'b0, b};
  assign is_shift = (op == OP_SLA) || (op == OP_SRA) || (op == OP_SRL);
  assign last     = (cnt == CW'(1));

  // Single-cycle result; shifts land here only for a zero shift amount
  always_comb begin
    c_res = '0;
    c_cry = 1'b0;
    c_ill = 1'b0;
    case (op)
      OP_ADD: begin c_res = sum_ab[WIDTH-1:0]; c_cry = sum_ab[WIDTH]; end
      OP_SUB: begin c_res = dif_ab[WIDTH-1:0]; c_cry = dif_ab[WIDTH]; end
      OP_AND: c_res = a & b;
      OP_OR:  c_res = a | b;
      OP_XOR: c_res = a ^ b;
      OP_NOT: c_res = ~a;
      OP_SLA, OP_SRA, OP_SRL: c_res = a;
      OP_MUL: c_res = '0;
      default: c_ill = 1'b1;
    endcase
  end

  // One-bit shift step; sh_out is the bit falling off the end
  always_comb begin
    sh_nxt = acc;
    sh_out = 1'b0;
    case (op_q)
      OP_SLA: begin sh_nxt = {acc[WIDTH-2:0], 1'b0}; sh_out = acc[WIDTH-1]; end
      OP_SRA: begin sh_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]}; sh_out = acc[0]; end
      default: begin sh_nxt = {1'b0, acc[WIDTH-1:1]}; sh_out = acc[0]; end
    endcase
  end

  // Shift-add step: conditionally add multiplicand to high half, then shift {carry,hi,lo} right
  always_comb begin
    mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], mq[WIDTH-1:1]};
  end

  // Control FSM with registered outputs; flags change only on entry to DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      a_q     <= '0;
      acc     <= '0;
      mq      <= '0;
      op_q    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      sign    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      wb_en   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            op_q    <= op;
            wb_addr <= rd;
            busy    <= 1'b1;
            if (is_shift && (n != '0)) begin
              acc   <= a;
              cnt   <= CW'(n);
              state <= SHIFT;
            end else if (op == OP_MUL) begin
              acc   <= '0;
              mq    <= b;
              cnt   <= CW'(WIDTH);
              state <= MUL;
            end else begin
              result  <= c_res;
              carry   <= c_cry;
              zero    <= (c_res == '0);
              sign    <= c_res[WIDTH-1];
              done    <= 1'b1;
              wb_en   <= !c_ill && (rd != '0);
              illegal <= c_ill;
              state   <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= sh_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= sh_nxt;
            carry  <= sh_out;
            zero   <= (sh_nxt == '0);
            sign   <= sh_nxt[WIDTH-1];
            done   <= 1'b1;
            wb_en  <= (wb_addr != '0);
            state  <= DONE;
          end
        end
        MUL: begin
          acc <= mul_hi;
          mq  <= mul_lo;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= mul_lo;
            carry  <= (mul_hi != '0);
            zero   <= (mul_lo == '0);
            sign   <= mul_lo[WIDTH-1];
            done   <= 1'b1;
            wb_en  <= (wb_addr != '0);
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: each scenario drives vectors and checks hand-computed results.
// Latency is measured in cycles after the accepting edge (cycle T+k).
// Outputs are sampled on the falling edge.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic        zero;
  logic        carry;
  logic        sign;
  logic        illegal;

  logic [6:0]  flags;
  int          total;
  int          bad;

  assign flags = {busy, done, wb_en, illegal, carry, zero, sign};

  alu_seq #(.WIDTH(32), .ADDR_W(4), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .done(done), .result(result), .wb_en(wb_en), .wb_addr(wb_addr),
    .zero(zero), .carry(carry), .sign(sign), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one edge; returns in the middle of cycle T+1
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] r);
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat = k where done is seen in cycle T+k (100 means timeout)
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int nd;
    reset = 1'b0; start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; rd = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (flags !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0); end
    total++; if (result !== 32'd0 || wb_addr !== 4'd0) begin bad++;
      $display("FAIL reset_result got=%h/%0d exp=0/0", result, wb_addr); end
    reset = 1'b1; start = 1'b0;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL reset_idle got=%0d active cycles exp=0", nd); end
  endtask

  task automatic test_arith();
    int lat;
    issue(4'd0, 32'd12, 32'd8, 4'd3);
    wait_done(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
    total++; if (result !== 32'd20 || wb_addr !== 4'd3) begin bad++;
      $display("FAIL add_result got=%0d/%0d exp=20/3", result, wb_addr); end
    total++; if (flags !== 7'b1110000) begin bad++; $display("FAIL add_flags got=%b exp=%b", flags, 7'b1110000); end
    @(negedge clk);
    total++; if (flags !== 7'b0000000 || result !== 32'd20) begin bad++;
      $display("FAIL add_hold got=%b/%0d exp=%b/20", flags, result, 7'b0); end

    issue(4'd1, 32'd8, 32'd12, 4'd5);
    wait_done(lat);
    total++; if (lat !== 1 || result !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL sub_result got=%0d/%h exp=1/fffffffc", lat, result); end
    total++; if (flags !== 7'b1110101) begin bad++; $display("FAIL sub_flags got=%b exp=%b", flags, 7'b1110101); end

    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd1);
    wait_done(lat);
    total++; if (result !== 32'd0 || flags !== 7'b1110110) begin bad++;
      $display("FAIL add_wrap got=%h/%b exp=0/%b", result, flags, 7'b1110110); end
  endtask

  task automatic test_logic();
    int lat;
    issue(4'd3, 32'h0000_00F0, 32'h0000_000F, 4'd2);
    wait_done(lat);
    total++; if (result !== 32'h0000_00FF || flags !== 7'b1110000) begin bad++;
      $display("FAIL or_result got=%h/%b exp=000000ff/%b", result, flags, 7'b1110000); end
    issue(4'd5, 32'd0, 32'h1234_5678, 4'd2);
    wait_done(lat);
    total++; if (result !== 32'hFFFF_FFFF || flags !== 7'b1110001) begin bad++;
      $display("FAIL not_result got=%h/%b exp=ffffffff/%b", result, flags, 7'b1110001); end
    issue(4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd2);
    wait_done(lat);
    total++; if (result !== 32'd0 || flags !== 7'b1110010) begin bad++;
      $display("FAIL xor_result got=%h/%b exp=0/%b", result, flags, 7'b1110010); end
  endtask

  task automatic test_shift();
    int lat;
    int nb;
    issue(4'd7, 32'h8000_0010, 32'd4, 4'd6);
    nb = 0;
    for (int i = 1; i <= 4; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) nb++;
      @(negedge clk);
    end
    total++; if (nb !== 0) begin bad++; $display("FAIL sra_busy got=%0d bad cycles exp=0", nb); end
    total++; if (done !== 1'b1 || result !== 32'hF800_0001) begin bad++;
      $display("FAIL sra_result got=%b/%h exp=1/f8000001", done, result); end
    total++; if (flags !== 7'b1110001) begin bad++; $display("FAIL sra_flags got=%b exp=%b", flags, 7'b1110001); end

    issue(4'd6, 32'h8000_0001, 32'd1, 4'd3);
    wait_done(lat);
    total++; if (lat !== 2 || result !== 32'd2 || flags !== 7'b1110100) begin bad++;
      $display("FAIL sla_result got=%0d/%h/%b exp=2/00000002/%b", lat, result, flags, 7'b1110100); end

    issue(4'd8, 32'd3, 32'd2, 4'd3);
    wait_done(lat);
    total++; if (lat !== 3 || result !== 32'd0 || flags !== 7'b1110110) begin bad++;
      $display("FAIL srl_result got=%0d/%h/%b exp=3/0/%b", lat, result, flags, 7'b1110110); end

    issue(4'd8, 32'h0000_1234, 32'h0000_0020, 4'd3);
    wait_done(lat);
    total++; if (lat !== 1 || result !== 32'h0000_1234 || flags !== 7'b1110000) begin bad++;
      $display("FAIL shift0_result got=%0d/%h/%b exp=1/00001234/%b", lat, result, flags, 7'b1110000); end
  endtask

  task automatic test_mul();
    int lat;
    issue(4'd9, 32'd60, 32'd56, 4'd15);
    wait_done(lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL mul_lat got=%0d exp=33", lat); end
    total++; if (result !== 32'd3360 || wb_addr !== 4'd15 || flags !== 7'b1110000) begin bad++;
      $display("FAIL mul_result got=%0d/%0d/%b exp=3360/15/%b", result, wb_addr, flags, 7'b1110000); end

    issue(4'd9, 32'h0001_0000, 32'h0001_0000, 4'd1);
    wait_done(lat);
    total++; if (lat !== 33 || result !== 32'd0 || flags !== 7'b1110110) begin bad++;
      $display("FAIL mul_ovf got=%0d/%h/%b exp=33/0/%b", lat, result, flags, 7'b1110110); end
  endtask

  task automatic test_back_to_back();
    int nd;
    int dc;
    int lat;
    issue(4'd9, 32'd3, 32'd5, 4'd4);
    nd = 0; dc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin nd++; dc = c; end
      start = (c == 5) || (done === 1'b1);
      if (c == 5) begin op = 4'd0; a = 32'd1; b = 32'd1; rd = 4'd7; end
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (nd !== 1 || dc !== 33) begin bad++;
      $display("FAIL ignore_start got=%0d dones at %0d exp=1 at 33", nd, dc); end
    total++; if (result !== 32'd15 || wb_addr !== 4'd4 || busy !== 1'b0) begin bad++;
      $display("FAIL ignore_result got=%0d/%0d/%b exp=15/4/0", result, wb_addr, busy); end

    issue(4'd2, 32'h0000_00FF, 32'h0000_000F, 4'd0);
    wait_done(lat);
    total++; if (result !== 32'h0000_000F || flags !== 7'b1100000 || wb_addr !== 4'd0) begin bad++;
      $display("FAIL and_r0 got=%h/%b/%0d exp=0000000f/%b/0", result, flags, wb_addr, 7'b1100000); end
  endtask

  task automatic test_reset_mid();
    int nd;
    int lat;
    issue(4'd9, 32'd7, 32'd9, 4'd6);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (flags !== 7'b0 || result !== 32'd0 || wb_addr !== 4'd0) begin bad++;
      $display("FAIL mid_reset got=%b/%h/%0d exp=%b/0/0", flags, result, wb_addr, 7'b0); end
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || wb_en === 1'b1) nd++;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL mid_abort got=%0d done cycles exp=0", nd); end

    issue(4'd12, 32'd5, 32'd5, 4'd9);
    wait_done(lat);
    total++; if (lat !== 1 || flags !== 7'b1101010) begin bad++;
      $display("FAIL illegal_flags got=%0d/%b exp=1/%b", lat, flags, 7'b1101010); end
    total++; if (result !== 32'd0 || wb_addr !== 4'd9) begin bad++;
      $display("FAIL illegal_result got=%h/%0d exp=0/9", result, wb_addr); end
    @(negedge clk);
    total++; if (flags !== 7'b0000010) begin bad++;
      $display("FAIL illegal_pulse got=%b exp=%b", flags, 7'b0000010); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle execute stage directly downstream of the register bank.
- Latches the two register read operands (r1_out/r2_out) plus opcode and destination index, and computes the result:
  - single-cycle for arithmetic and logic ops;
  - one bit per cycle for shifts;
  - 32-step shift-add for multiply.
- Returns result, destination index and a write-enable pulse that drive the bank's w_in / r3 / rw write port.
- Start/busy/done handshake lets the control FSM sequence read -> execute -> write-back.

Parameters:
- WIDTH, 32, datapath width; must match the register bank word width.
- ADDR_W, 4, register index width (16 registers).
- SHW, 5, shift-amount width; shift amount = b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- start  input  1  request; accepted only when busy=0.
- op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SLA, 7 SRA, 8 SRL, 9 MUL, 10-15 illegal.
- a  input  WIDTH  operand 1 (from r1_out).
- b  input  WIDTH  operand 2 (from r2_out); low SHW bits give the shift amount.
- rd  input  ADDR_W  destination register index.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  final result; held until the next completion.
- wb_en  output  1  write-back strobe to the bank (rw).
- wb_addr  output  ADDR_W  latched rd (to r3).
- zero  output  1  result==0; held.
- carry  output  1  carry/borrow/shift-out/overflow; held.
- sign  output  1  result[WIDTH-1]; held.
- illegal  output  1  one-cycle pulse for an unsupported opcode.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at an edge):
  - State goes to IDLE; every output goes to 0.
  - Internal operands, counter and accumulator clear.
  - Reset mid-operation aborts the operation; no done or wb_en is issued for it.
- States: IDLE, SHIFT, MUL, DONE.
- Start is accepted only in IDLE. Ignored in all other states, including DONE, so no queuing.
- Accepting start at edge T:
  - Latches a, b, op and rd (wb_addr = rd).
  - ADD/SUB/AND/OR/XOR/NOT/illegal: result computed at edge T, then go to DONE. done is high during cycle T+1.
  - SLA/SRA/SRL with n=b[SHW-1:0]:
    - n=0: result=a and carry=0, then DONE at T+1.
    - n>0: go to SHIFT with count=n; shift one bit per edge; after n edges go to DONE. done is high during cycle T+1+n.
  - MUL: unsigned shift-add for exactly 32 steps in state MUL. done is high during cycle T+33.
- DONE lasts exactly one cycle:
  - done=1; wb_en=1 unless the op is illegal or rd==0 (R0 stays zero).
  - Next state is IDLE, so the earliest next accept is T+2 after a single-cycle op.
- done, wb_en and illegal are 0 in every other cycle.
- result/zero/carry/sign update only on the edge entering DONE and hold otherwise.
- Arithmetic rules (all modulo 2^WIDTH):
  - ADD: carry = carry-out.
  - SUB: a-b; carry = borrow (1 iff a<b unsigned).
  - Logic ops and NOT: carry=0.
  - SLA: shift left, fill with 0; carry = last bit shifted out.
  - SRL: shift right, fill with 0.
  - SRA: shift right, replicate the sign bit.
  - SRL/SRA carry = last bit shifted out of bit 0.
  - MUL: result = low WIDTH bits of the product; carry=1 iff the high WIDTH bits are nonzero.
- Illegal opcode: result=0 and zero=1 with carry=0 and sign=0. illegal=1 and done=1 during the DONE cycle; wb_en=0.
- Inputs a/b/op/rd may change freely after acceptance; the latched copies are used.

Test Plan:
- Reset held low for 2 cycles, with start=1 during reset -> all outputs 0 and busy=0; no done after release until a new start.
- ADD a=12, b=8, rd=3 -> done and wb_en at T+1, result=20, wb_addr=3, carry=0, zero=0. Then SUB a=8, b=12 -> result=0xFFFFFFFC, carry=1, sign=1.
- SRA a=0x80000010, b=4 -> busy for cycles T+1..T+4, done at T+5, result=0xF8000001, carry=0. Shift with b=0 -> done at T+1, result=a.
- MUL a=60, b=56, rd=15 -> done at T+33, result=3360, carry=0. MUL a=0x10000, b=0x10000 -> result=0, zero=1, carry=1.
- Start pulsed during MUL and during the DONE cycle -> ignored; exactly one done. AND with rd=0 -> done=1, wb_en=0.
- reset driven low at T+10 of a MUL -> outputs 0 at the next edge, no done; op=12 after reset -> illegal=1 and done=1 at T+1, wb_en=0, result=0.
